// File: rtl/sdc_sim_pkg.sv
// Shared types and helpers for the SD-card sector server.
//   sdc_state_e          : transfer FSM states
//   SDC_SECTOR_BYTES     : default sector size in bytes
//   sector_out_of_range  : true when the whole sector does not fit in the image
package sdc_sim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAT,
    ST_FETCH,
    ST_WAIT,
    ST_STROBE,
    ST_GAP,
    ST_DONE
  } sdc_state_e;

  localparam int SDC_SECTOR_BYTES = 512;

  // End offset of the sector is formed in 64 bits so huge sector numbers
  // cannot wrap back into the image and look valid.
  function automatic logic sector_out_of_range(input logic [31:0] sector,
                                               input logic [31:0] size,
                                               input int          sector_bytes);
    logic [63:0] end_b;
    end_b = ({32'd0, sector} * 64'(sector_bytes)) + 64'(sector_bytes);
    return end_b > {32'd0, size};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the lowest requesting index at or after ptr,
// wrapping to index 0 when nothing at/above ptr is requesting.
//   req     : request vector
//   ptr     : starting index for this round
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : binary index of the grant
//   gnt_vld : any request present
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [N-1:0] mask;
  logic [N-1:0] sel;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr));
  end

  // Prefer requests at/after the pointer; fall back to the full vector.
  always_comb begin
    sel     = (|(req & mask)) ? (req & mask) : req;
    gnt_vld = |req;
    gnt_idx = '0;
    // Descending scan so the last hit (lowest index) wins.
    for (int i = N - 1; i >= 0; i--) if (sel[i]) gnt_idx = IW'(i);
    gnt = gnt_vld ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/sdc_sector_server.sv
// Multi-drive SD-card sector server. Serves one sector read at a time from a
// shared image memory port, pacing byte strobes to the core.
//   clk, reset              : clock, synchronous active-high reset
//   sdc_img_mounted/size    : per-drive image present / size in bytes
//   sdc_rd, sdc_sector      : per-drive level request, shared sector number
//   sdc_busy/done/err       : transfer status (done/err are one-cycle pulses)
//   sdc_byte_in_*           : byte strobe, index within sector, data
//   img_req/drive/addr      : memory read request pulse with drive and byte address
//   img_ack/data            : memory response, any latency >= 1
module sdc_sector_server
  import sdc_sim_pkg::*;
#(
  parameter  int DRIVES       = 4,
  parameter  int SECTOR_BYTES = SDC_SECTOR_BYTES,
  parameter  int START_LAT    = 16,
  parameter  int BYTE_GAP     = 2,
  parameter  int IMG_AW       = 32,
  localparam int AW           = $clog2(SECTOR_BYTES),
  localparam int DW           = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DRIVES-1:0]    sdc_img_mounted,
  input  logic [DRIVES*32-1:0] sdc_img_size,
  input  logic [DRIVES-1:0]    sdc_rd,
  input  logic [31:0]          sdc_sector,
  output logic                 sdc_busy,
  output logic                 sdc_done,
  output logic                 sdc_byte_in_strobe,
  output logic [AW-1:0]        sdc_byte_in_addr,
  output logic [7:0]           sdc_byte_in_data,
  output logic                 sdc_err,
  output logic                 img_req,
  output logic [DW-1:0]        img_drive,
  output logic [IMG_AW-1:0]    img_addr,
  input  logic                 img_ack,
  input  logic [7:0]           img_data
);

  localparam int CMAX = (START_LAT > BYTE_GAP) ? START_LAT : BYTE_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  sdc_state_e state, state_n;

  logic [DRIVES-1:0] armed;
  logic [DRIVES-1:0] elig;
  logic [DRIVES-1:0] gnt;
  logic [DW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [DW-1:0]     ptr;
  logic [DW-1:0]     drive;
  logic [31:0]       sector;
  logic              range_err;
  logic [AW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic [7:0]        byte_q;
  logic [31:0]       size_sel;
  logic [IMG_AW-1:0] byte_addr;
  logic              take;
  logic              last;

  // A drive is only offered to the arbiter once per rd assertion.
  assign elig = sdc_rd & sdc_img_mounted & armed;

  rr_arbiter #(.N(DRIVES)) u_arb (
    .req     (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    size_sel = '0;
    for (int i = 0; i < DRIVES; i++)
      if (gnt_idx == DW'(i)) size_sel = sdc_img_size[32*i +: 32];
  end

  // SECTOR_BYTES is a power of two, so the index simply fills the low bits.
  assign byte_addr = (IMG_AW'(sector) << AW) | IMG_AW'(idx);
  assign last      = (idx == AW'(SECTOR_BYTES - 1));

  always_comb begin
    state_n            = state;
    take               = 1'b0;
    sdc_busy           = 1'b0;
    sdc_done           = 1'b0;
    sdc_err            = 1'b0;
    sdc_byte_in_strobe = 1'b0;
    sdc_byte_in_addr   = '0;
    sdc_byte_in_data   = '0;
    img_req            = 1'b0;
    img_drive          = '0;
    img_addr           = '0;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_n = ST_LAT;
          take    = 1'b1;
        end
      end
      ST_LAT: begin
        sdc_busy = 1'b1;
        if (cnt == '0) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        sdc_busy = 1'b1;
        if (range_err) begin
          state_n = ST_STROBE;
        end else begin
          img_req   = 1'b1;
          img_drive = drive;
          img_addr  = byte_addr;
          state_n   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        sdc_busy = 1'b1;
        if (img_ack) state_n = ST_STROBE;
      end
      ST_STROBE: begin
        sdc_busy           = 1'b1;
        sdc_byte_in_strobe = 1'b1;
        sdc_byte_in_addr   = idx;
        sdc_byte_in_data   = byte_q;
        if (BYTE_GAP > 0) state_n = ST_GAP;
        else              state_n = last ? ST_DONE : ST_FETCH;
      end
      ST_GAP: begin
        sdc_busy = 1'b1;
        if (cnt == '0) state_n = last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        sdc_done = 1'b1;
        sdc_err  = range_err;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      armed     <= '1;
      ptr       <= '0;
      drive     <= '0;
      sector    <= '0;
      range_err <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      byte_q    <= '0;
    end else begin
      state <= state_n;
      // Re-arm whenever rd is low; the granted drive drops out until then.
      armed <= (armed | ~sdc_rd) & ~(take ? gnt : '0);
      case (state)
        ST_IDLE: begin
          if (take) begin
            drive     <= gnt_idx;
            sector    <= sdc_sector;
            range_err <= sector_out_of_range(sdc_sector, size_sel, SECTOR_BYTES);
            ptr       <= (gnt_idx == DW'(DRIVES - 1)) ? '0 : gnt_idx + 1'b1;
            idx       <= '0;
            cnt       <= CW'(START_LAT - 1);
          end
        end
        ST_LAT:   if (cnt != '0) cnt <= cnt - 1'b1;
        ST_FETCH: if (range_err) byte_q <= '0;
        ST_WAIT:  if (img_ack) byte_q <= img_data;
        ST_STROBE: begin
          if (BYTE_GAP > 0)              cnt <= CW'(BYTE_GAP - 1);
          else if (state_n == ST_FETCH) idx <= idx + 1'b1;
        end
        ST_GAP: begin
          if (cnt != '0)                cnt <= cnt - 1'b1;
          else if (state_n == ST_FETCH) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
